// File: rtl/hls_macc_key_loader.sv
// Byte-serial key loader and ap_ctrl_hs sequencer for the locked HLS MAC core.
// Build macro KEY_PARITY_CHECK_EN: when defined, each key must match its even-parity bit before it commits.
module hls_macc_key_loader #(
    parameter int KEY_W = 3071,
    parameter int SER_W = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             key_valid,
    input  logic [SER_W-1:0] key_data,
    input  logic             key_last,
    input  logic             key_par,
    output logic             key_ready,
    input  logic             start_req,
    output logic [KEY_W-1:0] locking_key,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             key_loaded,
    output logic             key_err,
    output logic             busy
);

    localparam int NBEATS = (KEY_W + SER_W - 1) / SER_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    function automatic logic key_parity(input logic [KEY_W-1:0] key);
        return ^key;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   beat_cnt_r;
    logic [CNT_W-1:0]   beat_cnt_s;
    logic [KEY_W-1:0]   shadow_r;
    wire  [KEY_W-1:0]   shadow_s;
    logic [KEY_W-1:0]   locking_key_r;
    logic               key_ready_r;
    logic               ap_start_r;
    logic               key_loaded_r;
    logic               key_err_r;
    logic               busy_r;
    logic               xfer_s;
    logic               commit_s;
    logic               parity_ok_s;

    assign xfer_s = key_valid & key_ready_r;

    // Shadow image with the current beat merged in; the last beat keeps only the bits that fit in KEY_W.
    for (genvar k = 0; k < NBEATS; k++) begin : g_beat
        localparam int LO = k * SER_W;
        localparam int HI = ((LO + SER_W) > KEY_W) ? KEY_W : (LO + SER_W);
        assign shadow_s[HI-1:LO] = (beat_cnt_r == CNT_W'(k)) ? key_data[HI-LO-1:0] : shadow_r[HI-1:LO];
    end

    // Key validation applied at the commit beat.
    always_comb begin
        parity_ok_s = 1'b0;
`ifdef KEY_PARITY_CHECK_EN
        parity_ok_s = (key_parity(shadow_s) == key_par);
`else
        // key_par has no influence in this build.
        parity_ok_s = key_par | 1'b1;
`endif
    end

    // Next-state and beat-counter logic.
    always_comb begin
        state_s    = state_r;
        beat_cnt_s = beat_cnt_r;
        commit_s   = 1'b0;
        case (state_r)
            ST_EMPTY, ST_LOAD, ST_ARMED: begin
                if (xfer_s) begin
                    if (beat_cnt_r == LAST_BEAT) begin
                        if (key_last && parity_ok_s) begin
                            commit_s   = 1'b1;
                            state_s    = ST_ARMED;
                            beat_cnt_s = CNT_ZERO;
                        end else begin
                            state_s    = ST_ERR;
                            beat_cnt_s = CNT_ZERO;
                        end
                    end else if (key_last) begin
                        state_s    = ST_ERR;
                        beat_cnt_s = CNT_ZERO;
                    end else begin
                        state_s    = ST_LOAD;
                        beat_cnt_s = beat_cnt_r + CNT_ONE;
                    end
                end else if ((state_r == ST_ARMED) && start_req) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (ap_ready) begin
                    state_s = ap_done ? ST_ARMED : ST_WAIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (ap_done) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s    = ST_ERR;
                beat_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r    <= ST_EMPTY;
            beat_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            beat_cnt_r <= beat_cnt_s;
        end
    end

    // Shadow assembly and atomic key commit; an error wipes the committed key.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            shadow_r      <= {KEY_W{1'b0}};
            locking_key_r <= {KEY_W{1'b0}};
        end else begin
            if (xfer_s) begin
                shadow_r <= shadow_s;
            end else begin
                shadow_r <= shadow_r;
            end
            if (commit_s) begin
                locking_key_r <= shadow_s;
            end else if (state_s == ST_ERR) begin
                locking_key_r <= {KEY_W{1'b0}};
            end else begin
                locking_key_r <= locking_key_r;
            end
        end
    end

    // Status and handshake outputs, registered from the next state so they align with it.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            key_ready_r  <= 1'b1;
            ap_start_r   <= 1'b0;
            key_loaded_r <= 1'b0;
            key_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            key_ready_r  <= (state_s == ST_EMPTY) || (state_s == ST_LOAD) || (state_s == ST_ARMED);
            ap_start_r   <= (state_s == ST_RUN);
            key_loaded_r <= (state_s == ST_ARMED) || (state_s == ST_RUN) || (state_s == ST_WAIT);
            key_err_r    <= (state_s == ST_ERR);
            busy_r       <= (state_s == ST_RUN) || (state_s == ST_WAIT);
        end
    end

    assign key_ready   = key_ready_r;
    assign locking_key = locking_key_r;
    assign ap_start    = ap_start_r;
    assign key_loaded  = key_loaded_r;
    assign key_err     = key_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_hls_macc_key_loader.sv
// Scoreboard bench for hls_macc_key_loader: stimulus queues expected commits, start pulses and errors;
// a negedge monitor checks them as the DUT presents them.
module tb_hls_macc_key_loader;

    localparam int KEY_W  = 3071;
    localparam int SER_W  = 8;
    localparam int NBEATS = 384;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             key_valid;
    logic [SER_W-1:0] key_data;
    logic             key_last;
    logic             key_par;
    logic             key_ready;
    logic             start_req;
    logic [KEY_W-1:0] locking_key;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             key_loaded;
    logic             key_err;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [KEY_W-1:0] commit_q[$];
    int               start_q[$];
    int               err_q[$];

    always #5 ap_clk = ~ap_clk;

    hls_macc_key_loader #(.KEY_W(KEY_W), .SER_W(SER_W)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .key_valid   (key_valid),
        .key_data    (key_data),
        .key_last    (key_last),
        .key_par     (key_par),
        .key_ready   (key_ready),
        .start_req   (start_req),
        .locking_key (locking_key),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .key_loaded  (key_loaded),
        .key_err     (key_err),
        .busy        (busy)
    );

    function automatic logic [7:0] beat_val(input int id, input int k);
        case (id)
            0:       return 8'hA5;
            1:       return 8'(k) ^ 8'h3C;
            default: return 8'h5A + 8'(k * 7);
        endcase
    endfunction

    function automatic logic [KEY_W-1:0] model_key(input int id);
        logic [NBEATS*SER_W-1:0] full;
        full = '0;
        for (int k = 0; k < NBEATS; k++) full[k*SER_W +: SER_W] = beat_val(id, k);
        return full[KEY_W-1:0];
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_key(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
                     act[KEY_W-1 -: 32], act[63:0], exp[KEY_W-1 -: 32], exp[63:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT commits a key, ends an ap_start pulse, or raises key_err.
    logic prev_loaded = 1'b0;
    logic prev_err    = 1'b0;
    logic prev_start  = 1'b0;
    int   start_len   = 0;
    always @(negedge ap_clk) begin
        if (key_loaded === 1'b1 && prev_loaded !== 1'b1) begin
            if (commit_q.size() == 0) chk_int("unexpected_commit", 1, 0);
            else chk_key("commit_key", locking_key, commit_q.pop_front());
        end
        if (key_err === 1'b1 && prev_err !== 1'b1) begin
            if (err_q.size() == 0) chk_int("unexpected_err", 1, 0);
            else begin
                void'(err_q.pop_front());
                chk_key("err_key_zero", locking_key, '0);
                chk_bit("err_loaded_low", key_loaded, 1'b0);
            end
        end
        if (ap_start === 1'b1) start_len++;
        if (ap_start === 1'b0 && prev_start === 1'b1) begin
            if (start_q.size() == 0) chk_int("unexpected_ap_start", start_len, 0);
            else chk_int("ap_start_len", start_len, start_q.pop_front());
            start_len = 0;
        end
        prev_loaded = key_loaded;
        prev_err    = key_err;
        prev_start  = ap_start;
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_key(input int id, input int n, input bit last_on_final, input bit flip_par,
                            input bit start_on_first, input bit chk_old, input logic [KEY_W-1:0] old_key);
        logic par;
        par = (^model_key(id)) ^ flip_par;
        for (int b = 0; b < n; b++) begin
            key_valid = 1'b1;
            key_data  = beat_val(id, b);
            key_last  = last_on_final && (b == n - 1);
            key_par   = par;
            start_req = start_on_first && (b == 0);
            if (b == 1) chk_bit("ready_in_load", key_ready, 1'b1);
            if (chk_old && b == 1) chk_bit("loaded_drops", key_loaded, 1'b0);
            if (chk_old && b == 200) chk_key("old_key_held", locking_key, old_key);
            tick();
        end
        key_valid = 1'b0;
        key_last  = 1'b0;
        start_req = 1'b0;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk_key({tag, "_key"}, locking_key, '0);
        chk_bit({tag, "_loaded"}, key_loaded, 1'b0);
        chk_bit({tag, "_err"}, key_err, 1'b0);
        chk_bit({tag, "_busy"}, busy, 1'b0);
        chk_bit({tag, "_ap_start"}, ap_start, 1'b0);
        chk_bit({tag, "_ready"}, key_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: simulation time budget exhausted");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        ap_rst = 1'b1; key_valid = 1'b0; key_data = 8'h00; key_last = 1'b0; key_par = 1'b0;
        start_req = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
        repeat (3) tick();
        chk_reset_state("reset");
        ap_rst = 1'b0;
        tick();

        // Full A5 key, committed one cycle after the last beat.
        commit_q.push_back(model_key(0));
        send_key(0, NBEATS, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk_bit("loaded_after_commit", key_loaded, 1'b1);
        chk_bit("ready_armed", key_ready, 1'b1);

        // Run: ap_ready seen on the 4th cycle of ap_start; key stream blocked while busy.
        start_q.push_back(4);
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        chk_bit("busy_in_run", busy, 1'b1);
        repeat (3) tick();
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        chk_bit("ap_start_cleared", ap_start, 1'b0);
        chk_bit("busy_in_wait", busy, 1'b1);
        key_valid = 1'b1;
        key_data  = 8'hFF;
        repeat (9) tick();
        chk_bit("ready_low_busy", key_ready, 1'b0);
        chk_key("key_stable_busy", locking_key, model_key(0));
        ap_done = 1'b1;
        tick();
        ap_done   = 1'b0;
        key_valid = 1'b0;
        chk_bit("busy_after_done", busy, 1'b0);
        chk_bit("ready_after_done", key_ready, 1'b1);
        chk_key("key_after_done", locking_key, model_key(0));

        // Reload while start_req collides with the first beat: load wins, no ap_start.
        commit_q.push_back(model_key(1));
        send_key(1, NBEATS, 1'b1, 1'b0, 1'b1, 1'b1, model_key(0));
        chk_bit("reload_committed", key_loaded, 1'b1);
        chk_bit("no_start_on_reload", ap_start, 1'b0);

        // Wrong key_par on the last beat.
`ifdef KEY_PARITY_CHECK_EN
        err_q.push_back(1);
        send_key(2, NBEATS, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk_bit("bad_par_err", key_err, 1'b1);
        chk_key("bad_par_no_commit", locking_key, '0);
`else
        commit_q.push_back(model_key(2));
        send_key(2, NBEATS, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk_bit("bad_par_ignored", key_err, 1'b0);
        chk_key("bad_par_commit", locking_key, model_key(2));
`endif

        // Reset in the middle of a load discards the partial key.
        do_reset();
        send_key(1, 50, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        ap_rst = 1'b1;
        tick();
        chk_reset_state("midload_reset");
        ap_rst = 1'b0;

        // Commit a key, then key_last on beat 100 forces ERR and clears locking_key.
        commit_q.push_back(model_key(2));
        send_key(2, NBEATS, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        err_q.push_back(1);
        send_key(1, 101, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk_bit("early_last_err", key_err, 1'b1);
        chk_key("early_last_key", locking_key, '0);
        chk_bit("err_ready_low", key_ready, 1'b0);
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        repeat (5) tick();
        chk_bit("err_no_start", ap_start, 1'b0);
        chk_bit("err_sticky", key_err, 1'b1);
        do_reset();
        chk_reset_state("err_reset");

        // Final beat without key_last is a framing error.
        err_q.push_back(1);
        send_key(0, NBEATS, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk_bit("missing_last_err", key_err, 1'b1);
        do_reset();
        chk_reset_state("final_reset");

        repeat (3) tick();
        chk_int("commit_q_drained", commit_q.size(), 0);
        chk_int("start_q_drained", start_q.size(), 0);
        chk_int("err_q_drained", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
